// File: rtl/sequencer_pkg.sv
// Shared types and constants for the operator input sequencer and the register-file mux.
package sequencer_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_OP,
    SETUP,
    WRITE,
    EXEC,
    WAIT_DONE,
    SHOW
  } state_t;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_OP  = 2'd2;
  localparam logic [1:0] SEL_BUF = 2'd3;

  localparam logic [3:0] LED_A   = 4'b0001;
  localparam logic [3:0] LED_B   = 4'b0010;
  localparam logic [3:0] LED_OP  = 4'b0100;
  localparam logic [3:0] LED_RUN = 4'b1000;

  // Phase indicator for a selector value; the buffer selector means exec/show.
  function automatic logic [3:0] led_for_sel(input logic [1:0] sel);
    case (sel)
      SEL_A:   return LED_A;
      SEL_B:   return LED_B;
      SEL_OP:  return LED_OP;
      default: return LED_RUN;
    endcase
  endfunction

endpackage

// File: rtl/input_sequencer_if.sv
// Selector/enable/data bus between the input sequencer (master) and the register-file mux (slave).
interface input_sequencer_if;
  logic [1:0] seletor;
  logic       enable;
  logic [7:0] dataOut;

  modport master (output seletor, enable, dataOut);
  modport slave  (input  seletor, enable, dataOut);
endinterface

// File: rtl/key_debounce.sv
// Push-button synchronizer and debouncer; emits a one-cycle strobe per accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic resetn,
  input  logic key,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter only runs while the synchronized level differs from the accepted one,
  // so any bounce back to the accepted level restarts the qualification window.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
        press_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/input_sequencer.sv
// Operator front end: loads A, B and the opcode through the mux, starts the processor,
// then parks the selector on the result buffer.
module input_sequencer
  import sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      key,
  input  logic [7:0]                switches,
  input  logic                      done,
  input_sequencer_if.master         bus,
  output logic                      execute,
  output logic [3:0]                stateLeds
);

  logic       press;
  state_t     state_q;
  logic [1:0] sel_q;
  logic       en_q;
  logic       exec_q;
  logic [7:0] data_q;
  logic [3:0] leds_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock  (clock),
    .resetn (resetn),
    .key    (key),
    .press  (press)
  );

  // sel_q doubles as the record of which phase is being written during SETUP/WRITE.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= LOAD_A;
      sel_q   <= SEL_A;
      en_q    <= 1'b0;
      exec_q  <= 1'b0;
      data_q  <= 8'h00;
      leds_q  <= LED_A;
    end else begin
      en_q   <= 1'b0;
      exec_q <= 1'b0;
      case (state_q)
        LOAD_A, LOAD_B, LOAD_OP: begin
          if (press) begin
            data_q  <= switches;
            sel_q   <= (state_q == LOAD_A) ? SEL_A : (state_q == LOAD_B) ? SEL_B : SEL_OP;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          en_q    <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          leds_q <= led_for_sel(sel_q + 2'd1);
          case (sel_q)
            SEL_A:   state_q <= LOAD_B;
            SEL_B:   state_q <= LOAD_OP;
            default: begin
              state_q <= EXEC;
              exec_q  <= 1'b1;
              sel_q   <= SEL_BUF;
            end
          endcase
        end
        EXEC:      state_q <= WAIT_DONE;
        WAIT_DONE: if (done) state_q <= SHOW;
        SHOW: begin
          if (press) begin
            state_q <= LOAD_A;
            sel_q   <= SEL_A;
            leds_q  <= LED_A;
          end
        end
        default:   state_q <= LOAD_A;
      endcase
    end
  end

  assign bus.seletor = sel_q;
  assign bus.enable  = en_q;
  assign bus.dataOut = data_q;
  assign execute     = exec_q;
  assign stateLeds   = leds_q;

endmodule

// File: tb/tb_input_sequencer.sv
// Bench for input_sequencer: table-driven load/handshake vectors, hand-written corner
// sequences and randomized operation streams against a phase-level reference model.
module tb_input_sequencer;

  localparam int DEB = 8;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       key = 1'b1;
  logic       done = 1'b0;
  logic [7:0] switches = 8'h00;
  logic       execute;
  logic [3:0] stateLeds;

  input_sequencer_if bus ();

  input_sequencer #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .key       (key),
    .switches  (switches),
    .done      (done),
    .bus       (bus.master),
    .execute   (execute),
    .stateLeds (stateLeds)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Monitor: records every write pulse and execute pulse seen on the outputs.
  logic [9:0] act_q[$];
  int         act_ex = 0;
  int         proto_err = 0;
  int         cyc = 0;
  int         last_en_cyc = -100;
  int         last_ex_cyc = -200;
  logic [1:0] ex_sel = 2'd0;
  logic       prev_en = 1'b0;
  logic [1:0] prev_sel = 2'd0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (bus.enable) begin
      act_q.push_back({bus.seletor, bus.dataOut});
      last_en_cyc = cyc;
      if (prev_en || prev_sel != bus.seletor || prev_data != bus.dataOut) proto_err = proto_err + 1;
    end
    if (execute) begin
      act_ex = act_ex + 1;
      last_ex_cyc = cyc;
      ex_sel = bus.seletor;
    end
    if (bus.enable && execute) proto_err = proto_err + 1;
    prev_en   = bus.enable;
    prev_sel  = bus.seletor;
    prev_data = bus.dataOut;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: phase 0/1/2 = loading A/B/opcode, 3 = busy, 4 = showing result.
  int         m_phase;
  logic [1:0] m_sel;
  logic [7:0] m_data;
  int         m_ex;
  logic       m_done;
  logic [9:0] exp_q[$];

  task automatic model_reset();
    m_phase = 0; m_sel = 2'd0; m_data = 8'h00; m_ex = 0; m_done = 1'b0;
    exp_q.delete();
  endtask

  function automatic int m_leds();
    case (m_phase)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 8;
    endcase
  endfunction

  task automatic model_press(input logic [7:0] sw);
    if (m_phase < 3) begin
      exp_q.push_back({2'(m_phase), sw});
      m_data = sw;
      if (m_phase < 2) begin
        m_sel = 2'(m_phase);
        m_phase = m_phase + 1;
      end else begin
        m_sel = 2'd3;
        m_ex = m_ex + 1;
        m_phase = m_done ? 4 : 3;
      end
    end else if (m_phase == 4) begin
      m_phase = 0;
      m_sel = 2'd0;
    end
  endtask

  task automatic model_done(input logic lvl);
    m_done = lvl;
    if (lvl && m_phase == 3) m_phase = 4;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; key = 1'b1; done = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(1);
    act_q.delete();
    act_ex = 0;
    model_reset();
  endtask

  task automatic press(input logic [7:0] sw, input int hold);
    switches = sw;
    key = 1'b0;
    tick(hold);
    key = 1'b1;
    tick(16);
  endtask

  task automatic check_all(input string tag);
    chk({tag, " write count"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0)
      chk({tag, " write sel/data"}, int'(act_q.pop_front()), int'(exp_q.pop_front()));
    act_q.delete();
    exp_q.delete();
    chk({tag, " execute count"}, act_ex, m_ex);
    chk({tag, " seletor"}, int'(bus.seletor), int'(m_sel));
    chk({tag, " dataOut"}, int'(bus.dataOut), int'(m_data));
    chk({tag, " stateLeds"}, int'(stateLeds), m_leds());
  endtask

  typedef struct {
    int         op;      // 0 press, 1 idle 20 cycles with done low, 2 done pulse
    logic [7:0] sw;
    logic [1:0] e_sel;
    logic [7:0] e_data;
    logic [3:0] e_leds;
    int         e_nwr;
    logic [9:0] e_wr;
    int         e_ex;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // Reset values while resetn is held low.
    tick(3);
    chk("reset seletor", int'(bus.seletor), 0);
    chk("reset enable", int'(bus.enable), 0);
    chk("reset execute", int'(execute), 0);
    chk("reset dataOut", int'(bus.dataOut), 0);
    chk("reset stateLeds", int'(stateLeds), 1);
    resetn = 1'b1;
    act_q.delete();
    act_ex = 0;
    tick(100);
    chk("idle no enable", act_q.size(), 0);
    chk("idle no execute", act_ex, 0);

    // Full load, handshake, ignored press and return to LOAD_A.
    tbl[0] = '{0, 8'h12, 2'd0, 8'h12, 4'b0010, 1, {2'd0, 8'h12}, 0};
    tbl[1] = '{0, 8'h34, 2'd1, 8'h34, 4'b0100, 1, {2'd1, 8'h34}, 0};
    tbl[2] = '{0, 8'h0A, 2'd3, 8'h0A, 4'b1000, 1, {2'd2, 8'h0A}, 1};
    tbl[3] = '{1, 8'h00, 2'd3, 8'h0A, 4'b1000, 0, 10'h000, 1};
    tbl[4] = '{0, 8'h55, 2'd3, 8'h0A, 4'b1000, 0, 10'h000, 1};
    tbl[5] = '{2, 8'h00, 2'd3, 8'h0A, 4'b1000, 0, 10'h000, 1};
    tbl[6] = '{0, 8'h77, 2'd0, 8'h0A, 4'b0001, 0, 10'h000, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      case (tbl[i].op)
        0: press(tbl[i].sw, 18);
        1: begin done = 1'b0; tick(20); end
        default: begin done = 1'b1; tick(2); done = 1'b0; tick(2); end
      endcase
      chk($sformatf("vec%0d write count", i), act_q.size(), tbl[i].e_nwr);
      if (tbl[i].e_nwr > 0 && act_q.size() > 0)
        chk($sformatf("vec%0d write", i), int'(act_q[$]), int'(tbl[i].e_wr));
      chk($sformatf("vec%0d execute count", i), act_ex, tbl[i].e_ex);
      chk($sformatf("vec%0d seletor", i), int'(bus.seletor), int'(tbl[i].e_sel));
      chk($sformatf("vec%0d dataOut", i), int'(bus.dataOut), int'(tbl[i].e_data));
      chk($sformatf("vec%0d stateLeds", i), int'(stateLeds), int'(tbl[i].e_leds));
      if (i == 2) begin
        chk("execute one cycle after write", last_ex_cyc - last_en_cyc, 1);
        chk("seletor during execute", int'(ex_sel), 3);
      end
      act_q.delete();
    end

    // Bouncing key: only the final stable low level is accepted.
    do_reset();
    switches = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      key = ~key;
      tick(3);
    end
    key = 1'b0;
    tick(20);
    key = 1'b1;
    tick(16);
    model_press(8'h5A);
    check_all("bounce");

    // Holding the key gives exactly one press.
    press(8'h21, 120);
    model_press(8'h21);
    check_all("held key");

    // Reset during the WRITE cycle of B.
    do_reset();
    press(8'h11, 18);
    model_press(8'h11);
    check_all("pre-reset A");
    switches = 8'h22;
    key = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.enable && n < 60) begin
        @(negedge clock);
        n++;
      end
      chk("write B seen", int'(bus.enable), 1);
      chk("write B seletor", int'(bus.seletor), 1);
    end
    resetn = 1'b0;
    key = 1'b1;
    @(posedge clock);
    #1;
    chk("reset in WRITE enable", int'(bus.enable), 0);
    chk("reset in WRITE stateLeds", int'(stateLeds), 1);
    chk("reset in WRITE seletor", int'(bus.seletor), 0);
    tick(2);
    resetn = 1'b1;
    tick(1);
    act_q.delete();
    act_ex = 0;
    model_reset();
    press(8'h33, 18);
    model_press(8'h33);
    check_all("after reset A");

    // Randomized operation stream.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [7:0] sw;
      r = $urandom_range(0, 5);
      sw = 8'($urandom);
      case (r)
        0, 1, 2: begin
          press(sw, $urandom_range(14, 30));
          model_press(sw);
        end
        3: begin done = 1'b1; tick(2); model_done(1'b1); end
        4: begin done = 1'b0; tick(2); model_done(1'b0); end
        default: tick($urandom_range(1, 20));
      endcase
      check_all($sformatf("rand%0d", i));
    end

    chk("enable/execute protocol errors", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_sequencer.md
# input_sequencer

Operator-side front end for the register-file mux: turns the board's push button and 8 slide switches into the selector/enable write sequence that loads register A, register B and the instruction byte. It then starts the processor, waits for completion and parks the selector on the result buffer for display. It is the initiator of the mux's selector/enable/data interface.

## Interface
- DEBOUNCE_CYCLES, 50000, clocks the button must be stable before a press or release is accepted; 1 ms at 50 MHz.
- clock  in  1  system clock; all logic on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- key  in  1  raw push button, active-low (pressed = 0), asynchronous to clock.
- switches  in  8  operator data byte, asynchronous.
- done  in  1  processor completion, level; meaningful only in WAIT_DONE.
- seletor  out  2  mux selector: 0 = A, 1 = B, 2 = instruction byte, 3 = result buffer.
- enable  out  1  mux write enable, one-cycle pulse.
- dataOut  out  8  byte presented to the mux `in` port.
- execute  out  1  one-cycle start pulse to the processor.
- stateLeds  out  4  one-hot phase indicator: bit0 A, bit1 B, bit2 opcode, bit3 exec/show.

## Operation
- Debounce: 2-flop synchronizer on key, then a counter. The counter clears on any change of the synchronized level. After DEBOUNCE_CYCLES consecutive equal samples, that level is accepted.
  - Accepted high→low transition produces one `press` strobe (1 cycle).
  - The next press requires an accepted release first. Holding the button never repeats.
- FSM states: LOAD_A, LOAD_B, LOAD_OP, SETUP, WRITE, EXEC, WAIT_DONE, SHOW.
- LOAD_A/LOAD_B/LOAD_OP on press:
  - Latch switches into dataOut.
  - Set seletor to 0/1/2.
  - Record the return phase and go to SETUP.
- SETUP: enable=0, one cycle, so seletor/dataOut are stable before the write edge. Next state is WRITE.
- WRITE: enable=1 for exactly one cycle. Next state:
  - LOAD_B after A.
  - LOAD_OP after B.
  - EXEC after the opcode.
- Between presses, seletor holds the last register written, so the mux choiceOut shows it.
- EXEC: execute=1 for one cycle; seletor←3. Next state is WAIT_DONE.
- WAIT_DONE: stays until done=1, then goes to SHOW.
  - done is not sampled in the EXEC cycle itself.
- SHOW: seletor=3. A press goes to LOAD_A with seletor←0. dataOut holds its last value.
- Presses arriving outside LOAD_A/LOAD_B/LOAD_OP/SHOW are discarded, not queued.
- stateLeds:
  - LOAD_A=0001, LOAD_B=0010, LOAD_OP=0100.
  - SETUP/WRITE show the phase being written.
  - EXEC/WAIT_DONE/SHOW=1000.

## Timing
- Reset (resetn=0 at an edge) forces:
  - FSM to LOAD_A and debouncer to accepted-high with counter 0.
  - seletor=0, enable=0, execute=0, dataOut=0x00, stateLeds=0001.
- Reset mid-WRITE drops enable at that same edge. A partially started sequence is abandoned.
- Press-to-enable latency: press strobe at cycle N, SETUP at N+1, enable high during N+2 only, new load state at N+3.
- Raw key edge to press strobe: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- The switches value is captured at the cycle the press strobe is seen. Switch changes after that do not alter the write.
- execute is high for exactly one cycle. A done that is already high when WAIT_DONE is entered completes immediately: SHOW on the next cycle.
- enable and execute are never high in the same cycle.

## Structure
- Shared package (`sequencer_pkg`): state enum, the selector constants SEL_A=0, SEL_B=1, SEL_OP=2, SEL_BUF=3 (also used by the mux), and the LED one-hot constants.
- Sub-module `key_debounce`: synchronizer, counter and press strobe. Parameter DEBOUNCE_CYCLES; ports clock, resetn, key, press.
- The top level holds the FSM and output registers only. All outputs are registered.

## Test plan
- Reset with key released: all outputs take their reset values; after 100 idle cycles there is no enable and no execute.
- Bounce: DEBOUNCE_CYCLES=8. Key toggles every 3 cycles for 30 cycles, then is held low → exactly one press, one SETUP, one enable pulse with seletor=0.
- Full load: three clean presses with switches 0x12, 0x34, 0x0A.
  - Enable pulses carry (seletor, dataOut) = (0,0x12), (1,0x34), (2,0x0A).
  - Each pulse is preceded by one SETUP cycle.
  - After the third write: execute is high one cycle later, and seletor=3.
- Handshake: done held low 20 cycles and then raised → remains in WAIT_DONE, stateLeds=1000. On done the FSM enters SHOW, and a press in SHOW returns to LOAD_A with seletor=0.
- Ignored press: a press during WAIT_DONE produces no enable and the state is unchanged. A held key yields no second press until released and re-pressed.
- Reset asserted in the WRITE cycle of B: enable goes low at that edge, the FSM is in LOAD_A, and seletor=0.
